// File: rtl/multi_cs_pkg.sv
// Shared types and helpers for the multi_cs_seq carry-save sequential multiplier.
package multi_cs_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Counter width for a bit index running 0..w-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/multi_cs_seq_cs_adder_row.sv
// Combinational row of full adders folding one partial product into a sum/carry pair.
module cs_adder_row #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_sum,
    input  logic [W-1:0] i_carry,
    input  logic [W-1:0] i_pp,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_carry
);

    logic [W-1:0] w_maj;

    assign w_maj   = (i_sum & i_carry) | (i_sum & i_pp) | (i_carry & i_pp);
    assign o_sum   = i_sum ^ i_carry ^ i_pp;
    // Carries land one bit up; the top carry falls outside the product width.
    assign o_carry = {w_maj[W-2:0], 1'b0};

endmodule

// File: rtl/multi_cs_seq.sv
// Sequential carry-save multiplier: one partial product per cycle, one final carry-propagate add.
// Define MULTI_CS_SIGNED_EN to add a signed_mode port selecting Baugh-Wooley signed operation.
module multi_cs_seq
    import multi_cs_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
`ifdef MULTI_CS_SIGNED_EN
    ,
    input  logic                 signed_mode
`endif
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = cnt_width(WIDTH);

    state_t          r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [PW-1:0]   r_sum;
    logic [PW-1:0]   r_carry;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_p;
    logic            r_in_ready;
    logic            r_out_valid;
`ifdef MULTI_CS_SIGNED_EN
    logic            r_signed;
`endif

    logic [WIDTH-1:0] w_row;
    logic [PW-1:0]    w_pp;
    logic [PW-1:0]    w_corr;
    logic [PW-1:0]    w_sum;
    logic [PW-1:0]    w_carry;

    // Partial product for bit r_cnt of b; signed mode inverts the Baugh-Wooley cross terms.
    always_comb begin
        w_row  = r_a & {WIDTH{r_b[r_cnt]}};
        w_corr = '0;
`ifdef MULTI_CS_SIGNED_EN
        if (r_signed) begin
            if (r_cnt == CW'(WIDTH - 1)) begin
                w_row = w_row ^ {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                w_row = w_row ^ {1'b1, {(WIDTH-1){1'b0}}};
            end
            w_corr = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
        end
`endif
        w_pp = PW'(w_row) << r_cnt;
    end

    cs_adder_row #(
        .W       (PW)
    ) u_row (
        .i_sum   (r_sum),
        .i_carry (r_carry),
        .i_pp    (w_pp),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= '0;
            r_cnt       <= '0;
            r_p         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef MULTI_CS_SIGNED_EN
            r_signed    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_sum      <= '0;
                        r_carry    <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ACCUM;
`ifdef MULTI_CS_SIGNED_EN
                        r_signed   <= signed_mode;
`endif
                    end
                end
                ACCUM: begin
                    r_sum   <= w_sum;
                    r_carry <= w_carry;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= RESOLVE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RESOLVE: begin
                    r_p         <= r_sum + r_carry + w_corr;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign p         = r_p;

endmodule

// File: tb/tb_multi_cs_seq.sv
// Self-checking bench for multi_cs_seq (WIDTH=4 and WIDTH=8 instances); signed cases under MULTI_CS_SIGNED_EN.
module tb_multi_cs_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] p;
    logic       signed_mode;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        out_valid8;
    logic        out_ready8;
    logic [15:0] p8;
    logic        signed_mode8;

    int checks;
    int errors;

    multi_cs_seq #(.WIDTH(4)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .p           (p)
`ifdef MULTI_CS_SIGNED_EN
        ,
        .signed_mode (signed_mode)
`endif
    );

    multi_cs_seq #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid8),
        .in_ready    (in_ready8),
        .a           (a8),
        .b           (b8),
        .out_valid   (out_valid8),
        .out_ready   (out_ready8),
        .p           (p8)
`ifdef MULTI_CS_SIGNED_EN
        ,
        .signed_mode (signed_mode8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference product: integer multiply, operands sign-extended in signed mode, truncated to 8 bits.
    function automatic logic [7:0] model4(input logic [3:0] x, input logic [3:0] y, input logic sm);
        int sx;
        int sy;
        sx = int'(x);
        sy = int'(y);
        if (sm) begin
            if (x[3]) sx -= 16;
            if (y[3]) sy -= 16;
        end
        return 8'(sx * sy);
    endfunction

    // One WIDTH=4 transaction: latency measured counting the accept edge as edge 1.
    task automatic run_op(input logic [3:0] x, input logic [3:0] y, input logic sm,
                          input int bp, input bit busy);
        logic [7:0] exp;
        int edges;
        exp = model4(x, y, sm);
        @(negedge clk);
        in_valid    = 1'b1;
        a           = x;
        b           = y;
        signed_mode = sm;
        out_ready   = (bp == 0);
        @(posedge clk);
        edges = 1;
        #1;
        check("accept_in_ready_low", in_ready, 1'b0);
        if (busy) begin
            a = 4'd1;
            b = 4'd1;
        end else begin
            in_valid = 1'b0;
            a = 4'($urandom);
            b = 4'($urandom);
        end
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            if (busy && !out_valid) check("busy_in_ready_low", in_ready, 1'b0);
        end
        check("latency", edges, 6);
        check("product", p, exp);
        if (bp > 0) begin
            repeat (bp) begin
                @(posedge clk);
                #1;
                check("bp_out_valid", out_valid, 1'b1);
                check("bp_p_stable", p, exp);
                check("bp_in_ready", in_ready, 1'b0);
            end
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("release_out_valid", out_valid, 1'b0);
        check("release_in_ready", in_ready, 1'b1);
        check("p_retained", p, exp);
        if (busy) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("busy_accept_in_idle", in_ready, 1'b0);
            edges = 1;
            while (!out_valid && edges < 40) begin
                @(posedge clk);
                edges++;
                #1;
            end
            check("busy_followup_latency", edges, 6);
            check("busy_followup_product", p, 8'd1);
            @(posedge clk);
            #1;
            check("busy_followup_release", out_valid, 1'b0);
        end
    endtask

    task automatic run8(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] exp;
        int edges;
        exp = 16'(int'(x) * int'(y));
        @(negedge clk);
        in_valid8  = 1'b1;
        a8         = x;
        b8         = y;
        out_ready8 = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        in_valid8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        while (!out_valid8 && edges < 60) begin
            @(posedge clk);
            edges++;
            #1;
        end
        check("w8_latency", edges, 10);
        check("w8_product", p8, exp);
        @(posedge clk);
        #1;
        check("w8_release", out_valid8, 1'b0);
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        a            = '0;
        b            = '0;
        out_ready    = 1'b0;
        signed_mode  = 1'b0;
        in_valid8    = 1'b0;
        a8           = '0;
        b8           = '0;
        out_ready8   = 1'b0;
        signed_mode8 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_p", p, 8'd0);
        check("rst_p_w8", p8, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd3,  4'd4,  1'b0, 0, 1'b0);
        run_op(4'd10, 4'd7,  1'b0, 0, 1'b0);
        run_op(4'd9,  4'd14, 1'b0, 0, 1'b0);
        run_op(4'd6,  4'd6,  1'b0, 0, 1'b0);
        run_op(4'd15, 4'd15, 1'b0, 0, 1'b0);
        run_op(4'd0,  4'd12, 1'b0, 0, 1'b0);
        run_op(4'd5,  4'd13, 1'b0, 0, 1'b0);
        run_op(4'd11, 4'd11, 1'b0, 0, 1'b0);

        run_op(4'd15, 4'd15, 1'b0, 10, 1'b0);
        run_op(4'd11, 4'd11, 1'b0, 0, 1'b1);

        // Abort 9*14 asynchronously in the second ACCUM cycle.
        @(negedge clk);
        in_valid = 1'b1;
        a = 4'd9;
        b = 4'd14;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_p", p, 8'd0);
        repeat (8) begin
            @(negedge clk);
            check("abort_hold_out_valid", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(4'd5, 4'd13, 1'b0, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            run_op(ra, rb, 1'b0, int'($urandom_range(0, 2)), 1'b0);
        end

`ifdef MULTI_CS_SIGNED_EN
        run_op(4'h8, 4'h8, 1'b1, 0, 1'b0);
        check("signed_m8xm8", p, 8'h40);
        run_op(4'hF, 4'h7, 1'b1, 0, 1'b0);
        check("signed_m1x7", p, 8'hF9);
        run_op(4'h7, 4'h8, 1'b1, 0, 1'b0);
        check("signed_7xm8", p, 8'hC8);
        run_op(4'hF, 4'hF, 1'b0, 0, 1'b0);
        check("signed_build_unsigned", p, 8'd225);
        for (int i = 0; i < 20; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            run_op(ra, rb, 1'($urandom), 0, 1'b0);
        end
`endif

        run8(8'd255, 8'd255);
        run8(8'd0, 8'd0);
        for (int i = 0; i < 6; i++) begin
            run8(8'($urandom), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
